// File: rtl/reg_cmd_pkg.sv
// Shared types for the register command sequencer: opcodes, FSM states, queued command record.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package reg_cmd_pkg;

    // Command record field widths; the sequencer's DEPTH/REP_W must not exceed these.
    localparam int CMD_ARG_W = 5;
    localparam int CMD_REP_W = 4;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_LOAD = 3'd1,
        OP_SHR  = 3'd2,
        OP_SHL  = 3'd3,
        OP_INC  = 3'd4,
        OP_DEC  = 3'd5
    } op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_e;

    typedef struct packed {
        op_e                  op;
        logic [CMD_ARG_W-1:0] arg;
        logic [CMD_REP_W-1:0] rep;
        logic                 logshift;
        logic                 loop;
    } cmd_t;

    // Map raw opcode bits onto the enum; the two unused encodings behave as NOP.
    function automatic op_e legal_op(input logic [2:0] raw);
        op_e r;
        case (raw)
            3'd1:    r = OP_LOAD;
            3'd2:    r = OP_SHR;
            3'd3:    r = OP_SHL;
            3'd4:    r = OP_INC;
            3'd5:    r = OP_DEC;
            default: r = OP_NOP;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/reg_cmd_fifo.sv
// Command queue: DEPTH==1 is a single holding register, otherwise a power-of-two ring buffer.
// Latency: an entry pushed at edge N is visible on rdata (empty low) after edge N; no bypass.
// Backpressure: full blocks push; flush empties the queue and drops a same-cycle push.
module reg_cmd_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    if (DEPTH == 1) begin : g_reg
        logic         r_vld;
        logic [W-1:0] r_dat;

        assign full  = r_vld;
        assign empty = ~r_vld;
        assign rdata = r_dat;

        // Occupancy flag: set by an accepted push, cleared by pop, reset or flush.
        always_ff @(posedge clk) begin
            if (!reset_n || flush) begin
                r_vld <= 1'b0;
            end else if (push && !r_vld) begin
                r_vld <= 1'b1;
            end else if (pop && r_vld) begin
                r_vld <= 1'b0;
            end
        end

        // Payload capture; contents are only meaningful while r_vld is set.
        always_ff @(posedge clk) begin
            if (push && !r_vld) begin
                r_dat <= wdata;
            end
        end
    end else begin : g_ring
        localparam int AW = $clog2(DEPTH);

        logic [W-1:0]  r_mem [DEPTH];
        logic [AW-1:0] r_wp;
        logic [AW-1:0] r_rp;
        logic [AW:0]   r_cnt;
        logic          w_wr;
        logic          w_rd;

        assign full  = (r_cnt == (AW+1)'(DEPTH));
        assign empty = (r_cnt == '0);
        assign rdata = r_mem[r_rp];
        assign w_wr  = push && !full;
        assign w_rd  = pop && !empty;

        // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
        always_ff @(posedge clk) begin
            if (!reset_n || flush) begin
                r_wp  <= '0;
                r_rp  <= '0;
                r_cnt <= '0;
            end else begin
                if (w_wr) r_wp <= r_wp + AW'(1);
                if (w_rd) r_rp <= r_rp + AW'(1);
                case ({w_wr, w_rd})
                    2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
                    2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
                    default: r_cnt <= r_cnt;
                endcase
            end
        end

        // Storage write; a write during flush is harmless since the pointers reset.
        always_ff @(posedge clk) begin
            if (w_wr) begin
                r_mem[r_wp] <= wdata;
            end
        end
    end

endmodule

// File: rtl/reg_cmd_seq.sv
// Command sequencer: queues commands and replays each as rep+1 cycles of one register strobe.
// Latency: command popped at edge N drives its first strobe after edge N; one IDLE cycle between commands.
// Backpressure: cmd_ready = queue not full; flush aborts execution and clears the queue.
// Build option REG_CMD_SEQ_FIFO_EN: FIFO_DEPTH-entry queue; undefined gives a single holding register.
module reg_cmd_seq
    import reg_cmd_pkg::*;
#(
    parameter int DEPTH      = 5,
    parameter int REP_W      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [DEPTH-1:0] cmd_arg,
    input  logic [REP_W-1:0] cmd_rep,
    input  logic             cmd_logshift,
    input  logic             cmd_loop,
    input  logic             flush,
    output logic             load,
    output logic             shr,
    output logic             shl,
    output logic             inc,
    output logic             dec,
    output logic             logshift,
    output logic             loop,
    output logic [DEPTH-1:0] in,
    output logic             busy,
    output logic             done
);

`ifdef REG_CMD_SEQ_FIFO_EN
    localparam int Q_DEPTH = FIFO_DEPTH;
`else
    localparam int Q_DEPTH = 1;
`endif

    cmd_t             w_cmd_in;
    cmd_t             w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_issue;

    state_e           r_state;
    op_e              r_op;
    logic [DEPTH-1:0] r_arg;
    logic [REP_W-1:0] r_cnt;
    logic             r_ls;
    logic             r_loop;

    // Illegal opcodes are folded to NOP on entry so the queue only ever holds legal ops.
    assign w_cmd_in = '{op:       legal_op(cmd_op),
                        arg:      CMD_ARG_W'(cmd_arg),
                        rep:      CMD_REP_W'(cmd_rep),
                        logshift: cmd_logshift,
                        loop:     cmd_loop};

    assign cmd_ready = ~w_full;
    assign w_push    = cmd_valid & ~w_full & ~flush;
    assign w_pop     = (r_state == ST_IDLE) & ~w_empty & ~flush;

    reg_cmd_fifo #(
        .W     ($bits(cmd_t)),
        .DEPTH (Q_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .push    (w_push),
        .pop     (w_pop),
        .wdata   (w_cmd_in),
        .rdata   (w_head),
        .full    (w_full),
        .empty   (w_empty)
    );

    // Sequencer FSM: latch the queue head in IDLE, count down strobe cycles in ISSUE.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_op    <= OP_NOP;
            r_arg   <= '0;
            r_cnt   <= '0;
            r_ls    <= 1'b0;
            r_loop  <= 1'b0;
        end else if (flush) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_state <= ST_ISSUE;
                        r_op    <= w_head.op;
                        r_arg   <= DEPTH'(w_head.arg);
                        // LOAD is a single-cycle write regardless of the repeat count.
                        r_cnt   <= (w_head.op == OP_LOAD) ? '0 : REP_W'(w_head.rep);
                        r_ls    <= w_head.logshift;
                        r_loop  <= w_head.loop;
                    end
                end
                ST_ISSUE: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - REP_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // All outputs decode registered state only; the op compare keeps the strobes one-hot.
    assign w_issue  = (r_state == ST_ISSUE);
    assign load     = w_issue & (r_op == OP_LOAD);
    assign shr      = w_issue & (r_op == OP_SHR);
    assign shl      = w_issue & (r_op == OP_SHL);
    assign inc      = w_issue & (r_op == OP_INC);
    assign dec      = w_issue & (r_op == OP_DEC);
    assign logshift = w_issue & r_ls;
    assign loop     = w_issue & r_loop;
    assign in       = r_arg;
    assign done     = w_issue & (r_cnt == '0);
    assign busy     = w_issue | ~w_empty;

endmodule

// File: tb/tb_reg_cmd_seq.sv
// Directed bench for reg_cmd_seq: reset, per-opcode sequencing, flush, mid-run reset, queue fill.
// Latency: inputs driven and outputs sampled 1ns after each rising edge.
// Backpressure: commands are offered only while cmd_ready is high.
module tb_reg_cmd_seq;
    import reg_cmd_pkg::*;

`ifdef REG_CMD_SEQ_FIFO_EN
    localparam int EXP_Q = 4;
`else
    localparam int EXP_Q = 1;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [4:0] cmd_arg;
    logic [3:0] cmd_rep;
    logic       cmd_logshift;
    logic       cmd_loop;
    logic       flush;
    logic       load, shr, shl, inc, dec, logshift, loop;
    logic [4:0] in_v;
    logic       busy, done;
    logic [4:0] strb;

    int n_checks = 0;
    int n_errors = 0;
    int n_sent, first_low, n_dec, n_inc, n_done, last_dec, max_gap, n_multi;
    logic acc;

    always #5 clk = ~clk;

    assign strb = {load, shr, shl, inc, dec};

    reg_cmd_seq #(.DEPTH(5), .REP_W(4), .FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_arg      (cmd_arg),
        .cmd_rep      (cmd_rep),
        .cmd_logshift (cmd_logshift),
        .cmd_loop     (cmd_loop),
        .flush        (flush),
        .load         (load),
        .shr          (shr),
        .shl          (shl),
        .inc          (inc),
        .dec          (dec),
        .logshift     (logshift),
        .loop         (loop),
        .in           (in_v),
        .busy         (busy),
        .done         (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [4:0] arg, input logic [3:0] rep,
                        input logic ls, input logic lp);
        chk("ready_before_send", cmd_ready, 1);
        cmd_op       = op;
        cmd_arg      = arg;
        cmd_rep      = rep;
        cmd_logshift = ls;
        cmd_loop     = lp;
        cmd_valid    = 1'b1;
        step();
        cmd_valid    = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_arg = 5'd0; cmd_rep = 4'd0;
        cmd_logshift = 1'b0; cmd_loop = 1'b0; flush = 1'b0;
        step(); step();
        chk("rst_strb", strb, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_in", in_v, 0);
        chk("rst_logshift", logshift, 0);
        chk("rst_loop", loop, 0);
        reset_n = 1'b1;
        step();
        chk("idle_empty_strb", strb, 0);
        chk("idle_empty_busy", busy, 0);

        // INC rep=2: three inc cycles, done on the third.
        send(3'd4, 5'd0, 4'd2, 1'b0, 1'b0);
        chk("inc_queued_busy", busy, 1);
        chk("inc_queued_strb", strb, 0);
        step(); chk("inc_c1", strb, 5'b00010); chk("inc_c1_done", done, 0);
        step(); chk("inc_c2", strb, 5'b00010); chk("inc_c2_done", done, 0);
        step(); chk("inc_c3", strb, 5'b00010); chk("inc_c3_done", done, 1);
        step(); chk("inc_end_strb", strb, 0); chk("inc_end_done", done, 0);
        chk("inc_end_busy", busy, 0);

        // LOAD ignores rep: single cycle with in = arg.
        send(3'd1, 5'b10101, 4'd7, 1'b0, 1'b0);
        step(); chk("load_c1", strb, 5'b10000); chk("load_in", in_v, 5'b10101);
        chk("load_done", done, 1);
        step(); chk("load_end_strb", strb, 0); chk("load_end_busy", busy, 0);
        chk("load_in_hold", in_v, 5'b10101);

        // SHR rep=3 logshift=1, flush during 2nd strobe with a same-cycle push.
        send(3'd2, 5'b00011, 4'd3, 1'b1, 1'b0);
        step(); chk("shr_c1", strb, 5'b01000); chk("shr_c1_ls", logshift, 1);
        chk("shr_in", in_v, 5'b00011);
        step(); chk("shr_c2", strb, 5'b01000); chk("shr_c2_done", done, 0);
        flush = 1'b1; cmd_valid = 1'b1; cmd_op = 3'd4; cmd_rep = 4'd0;
        step();
        flush = 1'b0; cmd_valid = 1'b0;
        chk("flush_strb", strb, 0); chk("flush_done", done, 0);
        chk("flush_busy", busy, 0); chk("flush_ready", cmd_ready, 1);
        chk("flush_ls", logshift, 0);
        step(); chk("flush_drop_busy", busy, 0); chk("flush_drop_strb", strb, 0);

        // SHL rep=0 with loop=1.
        send(3'd3, 5'd0, 4'd0, 1'b0, 1'b1);
        step(); chk("shl_c1", strb, 5'b00100); chk("shl_done", done, 1);
        chk("shl_loop", loop, 1);
        step(); chk("shl_end_strb", strb, 0); chk("shl_end_loop", loop, 0);

        // Illegal opcode 7 rep=1: two busy NOP cycles, loop held, done on the 2nd.
        send(3'd7, 5'b01111, 4'd1, 1'b0, 1'b1);
        step(); chk("op7_c1_strb", strb, 0); chk("op7_c1_busy", busy, 1);
        chk("op7_c1_loop", loop, 1); chk("op7_c1_done", done, 0);
        step(); chk("op7_c2_strb", strb, 0); chk("op7_c2_busy", busy, 1);
        chk("op7_c2_done", done, 1);
        step(); chk("op7_end_busy", busy, 0); chk("op7_end_done", done, 0);
        chk("op7_end_loop", loop, 0);

        // Reset during INC rep=9.
        send(3'd4, 5'd0, 4'd9, 1'b0, 1'b0);
        step(); chk("rstmid_c1", strb, 5'b00010);
        step(); chk("rstmid_c2", strb, 5'b00010);
        reset_n = 1'b0;
        step();
        chk("rstmid_strb", strb, 0); chk("rstmid_busy", busy, 0);
        chk("rstmid_done", done, 0); chk("rstmid_ready", cmd_ready, 1);
        chk("rstmid_in", in_v, 0);
        reset_n = 1'b1;
        step(); chk("rstmid_after_strb", strb, 0); chk("rstmid_after_busy", busy, 0);

        // INC rep=7 occupies the sequencer while five DEC rep=0 commands are offered back to back.
        cmd_op = 3'd4; cmd_arg = 5'd0; cmd_rep = 4'd7; cmd_logshift = 1'b0; cmd_loop = 1'b0;
        cmd_valid = 1'b1;
        step();
        cmd_op = 3'd5; cmd_rep = 4'd0;
        n_sent = 0; first_low = -1; n_dec = 0; n_inc = 0; n_done = 0;
        last_dec = -1; max_gap = 0; n_multi = 0;
        for (int c = 0; c < 40; c++) begin
            acc = cmd_valid && cmd_ready;
            step();
            if (acc) n_sent++;
            if (n_sent == 5) cmd_valid = 1'b0;
            if (!cmd_ready && n_sent > 0 && first_low < 0) first_low = n_sent;
            if (dec) begin
                n_dec++;
                if (last_dec >= 0 && (c - last_dec) > max_gap) max_gap = c - last_dec;
                last_dec = c;
            end
            if (inc) n_inc++;
            if (done) n_done++;
            if ($countones(strb) > 1) n_multi++;
        end
        cmd_valid = 1'b0;
        chk("q_sent", n_sent, 5);
        chk("q_ready_drop_depth", first_low, EXP_Q);
        chk("q_inc_cycles", n_inc, 8);
        chk("q_dec_cycles", n_dec, 5);
        chk("q_done_pulses", n_done, 6);
        chk("q_dec_spacing", max_gap, 2);
        chk("q_onehot", n_multi, 0);
        chk("q_end_busy", busy, 0);
        chk("q_end_ready", cmd_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reg_cmd_seq.md
REG_CMD_SEQ -- requirements
Module: reg_cmd_seq

Interface
REQ-001 The block SHALL have parameter DEPTH, default 5, meaning the data width of the downstream register value.
REQ-002 The block SHALL have parameter REP_W, default 4, meaning the width of the command repeat count.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the command FIFO entries (power of two).
REQ-004 The block SHALL have one clock; reset is synchronous and active-low: clk  in  1  rising-edge clock.
REQ-005 The block SHALL have reset_n  in  1  synchronous active-low reset.
REQ-006 The block SHALL have cmd_valid  in  1  command offered.
REQ-007 The block SHALL have cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-008 The block SHALL have cmd_op  in  3  opcode (NOP, LOAD, SHR, SHL, INC, DEC).
REQ-009 The block SHALL have cmd_arg  in  DEPTH  load value.
REQ-010 The block SHALL have cmd_rep  in  REP_W  repeat count; op executes cmd_rep+1 cycles.
REQ-011 The block SHALL have cmd_logshift, cmd_loop  in  1 each  mode bits captured with the command.
REQ-012 The block SHALL have flush  in  1  abort current and queued commands.
REQ-013 The block SHALL have load, shr, shl, inc, dec, logshift, loop  out  1 each  downstream register controls.
REQ-014 The block SHALL have in  out  DEPTH  downstream load value.
REQ-015 The block SHALL have busy  out  1 and done  out  1  status (done = one-cycle completion pulse).

Function
REQ-016 The FSM SHALL have states IDLE and ISSUE.
REQ-017 IDLE: if a command is available, it SHALL be popped on that edge, its fields latched, the repeat counter loaded with cmd_rep, and the state SHALL go to ISSUE.
REQ-018 ISSUE: exactly one control strobe matching the latched op SHALL be high per cycle, the counter decrementing each cycle.
REQ-019 ISSUE with counter==0: the last strobe SHALL be issued, done SHALL pulse in the same cycle, and the state SHALL return to IDLE.
REQ-020 LOAD SHALL issue exactly one cycle of load with in=arg, ignoring rep; NOP SHALL occupy rep+1 cycles with no strobe.
REQ-021 Strobes, in, logshift and loop SHALL be decoded from registered state only (no input-to-output combinational path).
REQ-022 Latency: a command popped at edge N SHALL drive its first strobe in the cycle following edge N.
REQ-023 logshift and loop SHALL hold the latched values throughout ISSUE and SHALL be 0 in IDLE.
REQ-024 in SHALL hold the last latched arg.
REQ-025 At most one of load/shr/shl/inc/dec SHALL be high in any cycle.
REQ-026 busy SHALL equal (state==ISSUE) or (FIFO not empty).
REQ-027 cmd_ready SHALL equal not-full, with no bypass; a simultaneous push and pop SHALL be legal when not full.
REQ-028 Empty FIFO in IDLE SHALL keep the block in IDLE with all strobes low.
REQ-029 flush SHALL take priority over everything: on that edge FIFO cleared, state to IDLE, no done; a push in the same cycle SHALL be discarded.
REQ-030 Illegal opcodes (6, 7) SHALL be treated as NOP.

Reset
REQ-031 With reset_n low at an edge: state IDLE, FIFO empty, counter 0, latched op NOP, arg 0.
REQ-032 Consequently, after reset every output SHALL be 0 except cmd_ready=1.
REQ-033 Reset mid-ISSUE SHALL abort with no further strobes and no done.

Configuration
REQ-034 Macro REG_CMD_SEQ_FIFO_EN defined: the command queue SHALL be a FIFO_DEPTH-entry FIFO.
REQ-035 Macro REG_CMD_SEQ_FIFO_EN undefined: the queue SHALL be a single holding register (full/empty semantics unchanged, capacity 1); all other behaviour SHALL be identical.

Structure
REQ-036 Package reg_cmd_pkg SHALL hold the opcode enum op_e, the state enum, and the command struct (op, arg, rep, logshift, loop).
REQ-037 The queue SHALL be sub-module reg_cmd_fifo (parameterised, flush input), instantiated by reg_cmd_seq.

Verification
REQ-038 The bench SHALL cover: reset then INC rep=2 -> inc high exactly 3 consecutive cycles starting the cycle after acceptance, done on 3rd cycle, busy low the cycle after.
REQ-039 The bench SHALL cover: LOAD arg=5'b10101 rep=7 -> single load cycle with in=5'b10101, done same cycle.
REQ-040 The bench SHALL cover: with FIFO_EN, 5 back-to-back DEC rep=0 pushes while the first executes -> cmd_ready drops when 4 are queued; all 5 execute, 5 done pulses, no gaps beyond one IDLE cycle each.
REQ-041 The bench SHALL cover: SHR rep=3 with logshift=1, flush asserted in the 2nd strobe cycle -> shr high exactly 2 cycles, no done, FIFO empty, cmd_ready=1.
REQ-042 The bench SHALL cover: reset_n low during ISSUE of INC rep=9 -> all strobes 0 next cycle, busy=0.
REQ-043 The bench SHALL cover: opcode 7 rep=1 -> 2 cycles busy, no strobes, done pulse.
